scaled_add_sub_pipe: RTL
========================

# scaled_add_sub_pipe

Pipelined, parametrised adder/subtractor for the ODE solver's scaled fixed-point words. The top SW bits of each word are an unsigned scale factor and the remaining MW = W−SW bits are a signed mantissa, with value = mantissa · 2^−scale. Scale alignment, add/sub, renormalisation and saturation run in a 3-stage pipeline with valid/ready handshakes. The block sits between the solver's operand sequencer and its accumulator registers.

## Interface
- W, 16, total word width
- SW, 3, scale-field width; MW = W−SW; internal width IW = MW + 2^SW
- RENORM, 1, on mantissa overflow, lower the result scale to fit before declaring overflow
- SATURATE, 1, on unrecoverable overflow, clamp the mantissa; 0 = wrap
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand presented
- in_ready  out  1  block accepts this cycle
- sub  in  1  0 = add, 1 = subtract
- cin  in  1  carry/borrow in
- in1, in2  in  W  scaled operands, scale in [W−1:MW]
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts
- out  out  W  scaled result
- cout  out  1  carry out of the IW-bit adder
- invalid  out  1  result overflowed (saturated or wrapped)

## Operation
- Stage 1, align:
  - s1, s2 = scale fields; sign-extend the mantissas to IW bits.
  - d = |s1−s2|. Shift the mantissa with the smaller scale left by d. S = max(s1, s2).
- Stage 2, add:
  - r = a + (b XOR {IW{sub}}) + (cin XOR sub), giving a+b+cin for add and a−b−cin for sub.
  - cout = unsigned carry out of bit IW−1.
  - r never overflows IW.
- Stage 3, normalise/pack:
  - r fits in MW signed bits: mantissa = r[MW−1:0], scale S, invalid = 0.
  - r does not fit and RENORM=1: take the smallest k ≤ S such that r>>>k (arithmetic shift, truncation toward −∞) fits. Result is mantissa r>>>k, scale S−k, invalid = 0.
  - No such k, or RENORM=0: invalid = 1.
    - SATURATE=1: mantissa = 2^(MW−1)−1 or −2^(MW−1) by the sign of r; scale = 0 if RENORM else S.
    - SATURATE=0: mantissa = r[MW−1:0] (wrap), scale S.
- A zero result keeps scale S (no upward normalisation).
- Flow control:
  - The pipeline uses a single global advance signal, adv = out_ready | ~out_valid.
  - in_ready = adv (combinational from out_ready).
  - When adv=0, all stage registers, including valids, hold their values.
  - Bubbles are not compressed while stalled.

## Timing
- Reset (rst high at a clock edge):
  - All stage valids and out_valid go to 0.
  - out = 0, cout = 0, invalid = 0.
  - In-flight operations are discarded. out_valid is 0 from the cycle after the reset edge.
  - in_ready = 1 during and after reset.
- Latency: an operand accepted at edge T (in_valid & in_ready) appears on out/out_valid after edge T+3, provided there is no stall.
- Throughput: 1 operation/cycle. Results leave in acceptance order.
- out, cout and invalid are registered and stable while out_valid=1 and out_ready=0.
- Simultaneous in_valid with out_ready=0 while out_valid=1: the input is not accepted. The source must hold its operands.
- Equal scales: d = 0, no shift. Maximum d = 2^SW−1 shifts without loss inside IW.

## Test plan
All cases use default parameters (W=16, SW=3, MW=13) unless stated.
- Same scale: in1=0x4064, in2=0x4032, sub=0, cin=0 -> out=0x4096, invalid=0, cout=0, out_valid exactly 3 cycles after acceptance.
- Scale alignment:
  - in1=0x6008, in2=0x2003, add -> out=0x6014.
  - Same operands with sub=1, cin=1 -> mantissa 8−12−1 = −5, out=0x7FFB.
- Renormalise: in1=in2=0x2FA0 (scale 1, 4000), add -> out=0x0FA0 (scale 0, 4000), invalid=0.
- Overflow: in1=in2=0x0FA0, add:
  - SATURATE=1 -> out=0x0FFF, invalid=1.
  - SATURATE=0 -> out=0x1F40, invalid=1.
  - With 0x1060+0x1060 (−4000 each) and SATURATE=1 -> out=0x1000.
- Backpressure: issue 6 back-to-back ops and drop out_ready for 4 cycles mid-stream -> in_ready low exactly while out_valid & ~out_ready, all 6 results correct and in order, no duplicates.
- Reset mid-flight: 2 ops in the pipe, then pulse rst for 1 cycle -> out_valid=0 and out=0 the next cycle, no stale result emitted, a new op issued afterwards has 3-cycle latency.

Source files
------------

// File: rtl/scaled_add_sub_pipe.sv
// scaled_add_sub_pipe: pipelined add/sub for scaled fixed-point words.
// Word layout: {scale[SW-1:0], mantissa[MW-1:0]}, value = mantissa * 2^-scale.
// Pipeline: input capture -> align -> add -> normalise/pack (registered out).
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The whole pipe moves on one global advance, adv = out_ready | ~out_valid.
// When adv is low every stage register (data and valid) holds, so bubbles are
// kept as-is. The source must hold in1/in2/sub/cin stable until accepted.
module scaled_add_sub_pipe #(
  parameter int W        = 16,
  parameter int SW       = 3,
  parameter int RENORM   = 1,
  parameter int SATURATE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic         cin,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         cout,
  output logic         invalid
);

  localparam int MW   = W - SW;
  localparam int IW   = MW + (1 << SW);
  // Largest renormalisation shift tried; only k = 0 when renormalising is off.
  localparam int KMAX = (RENORM != 0) ? ((1 << SW) - 1) : 0;

  // True when v is representable as an MW-bit signed number.
  function automatic logic fits_mw(input logic [IW-1:0] v);
    return (&v[IW-1:MW-1]) | ~(|v[IW-1:MW-1]);
  endfunction

  logic adv;

  assign adv      = out_ready | ~out_valid;
  // Reset clears out_valid on the reset edge, so ready is forced high meanwhile.
  assign in_ready = adv | rst;

  // ---------------- stage 0: operand capture ----------------
  logic         v0;
  logic [W-1:0] x1_q, x2_q;
  logic         sub0, cin0;

  // Capture the presented operands whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0   <= 1'b0;
      x1_q <= '0;
      x2_q <= '0;
      sub0 <= 1'b0;
      cin0 <= 1'b0;
    end else if (adv) begin
      v0   <= in_valid;
      x1_q <= in1;
      x2_q <= in2;
      sub0 <= sub;
      cin0 <= cin;
    end
  end

  // ---------------- stage 1: scale alignment ----------------
  logic [SW-1:0] sa, sb, s_max, d;
  logic [IW-1:0] ma, mb, a_al, b_al;

  // Bring both mantissas to the larger scale; the smaller-scale one is shifted
  // left by the scale difference. IW leaves room for the maximum shift.
  always_comb begin
    sa    = x1_q[W-1:MW];
    sb    = x2_q[W-1:MW];
    ma    = {{(IW-MW){x1_q[MW-1]}}, x1_q[MW-1:0]};
    mb    = {{(IW-MW){x2_q[MW-1]}}, x2_q[MW-1:0]};
    s_max = sa;
    d     = '0;
    a_al  = ma;
    b_al  = mb;
    if (sa >= sb) begin
      s_max = sa;
      d     = sa - sb;
      b_al  = mb << d;
    end else begin
      s_max = sb;
      d     = sb - sa;
      a_al  = ma << d;
    end
  end

  logic          v1;
  logic [IW-1:0] a1, b1;
  logic [SW-1:0] s1;
  logic          sub1, cin1;

  // Register aligned operands together with the common scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      s1   <= '0;
      sub1 <= 1'b0;
      cin1 <= 1'b0;
    end else if (adv) begin
      v1   <= v0;
      a1   <= a_al;
      b1   <= b_al;
      s1   <= s_max;
      sub1 <= sub0;
      cin1 <= cin0;
    end
  end

  // ---------------- stage 2: add / subtract ----------------
  logic [IW:0] sum;
  logic        ci;

  // a + b + cin for add, a + ~b + ~cin (= a - b - cin) for subtract.
  always_comb begin
    ci  = cin1 ^ sub1;
    sum = {1'b0, a1} + {1'b0, b1 ^ {IW{sub1}}} + {{IW{1'b0}}, ci};
  end

  logic          v2;
  logic [IW-1:0] r2;
  logic          c2;
  logic [SW-1:0] s2;

  // Register the IW-bit result, its carry-out and the scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      r2 <= '0;
      c2 <= 1'b0;
      s2 <= '0;
    end else if (adv) begin
      v2 <= v1;
      r2 <= sum[IW-1:0];
      c2 <= sum[IW];
      s2 <= s1;
    end
  end

  // ---------------- stage 3: normalise / pack ----------------
  logic          found;
  logic [SW-1:0] k_sel;
  logic [IW-1:0] sh, sh_sel;
  logic [MW-1:0] mant_n;
  logic [SW-1:0] scale_n;
  logic          inv_n;

  // Pick the smallest right shift k <= scale that makes the result fit; a zero
  // result fits at k = 0 and therefore keeps its scale.
  always_comb begin
    found  = 1'b0;
    k_sel  = '0;
    sh     = '0;
    sh_sel = r2;
    for (int k = 0; k <= KMAX; k++) begin
      sh = $signed(r2) >>> k;
      if (!found && (SW'(k) <= s2) && fits_mw(sh)) begin
        found  = 1'b1;
        k_sel  = SW'(k);
        sh_sel = sh;
      end
    end
    mant_n  = sh_sel[MW-1:0];
    scale_n = s2 - k_sel;
    inv_n   = 1'b0;
    if (!found) begin
      inv_n = 1'b1;
      if (SATURATE != 0) begin
        mant_n  = r2[IW-1] ? {1'b1, {(MW-1){1'b0}}} : {1'b0, {(MW-1){1'b1}}};
        scale_n = (RENORM != 0) ? '0 : s2;
      end else begin
        mant_n  = r2[MW-1:0];
        scale_n = s2;
      end
    end
  end

  // Output register; payload only reloads on a valid result so it stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      cout      <= 1'b0;
      invalid   <= 1'b0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        out     <= {scale_n, mant_n};
        cout    <= c2;
        invalid <= inv_n;
      end
    end
  end

endmodule
